// File: rtl/issue_select.sv
// issue_select: wakes queued ops from a result-tag broadcast, dequeues the oldest ready one
// and holds it in an output register that feeds one FU with a configurable initiation interval.
module issue_select #(
   parameter int N_ENTRIES     = 4,
   parameter int TAG_WIDTH     = 3,
   parameter int PAYLOAD_WIDTH = 4,
   parameter int ISSUE_II      = 1,
   localparam int ENTRY_WIDTH  = PAYLOAD_WIDTH + 2*TAG_WIDTH + 2
) (
   input  logic                             clk,
   input  logic                             rst_aL,
   input  logic                             flush,
   input  logic [N_ENTRIES-1:0]             entry_valid,
   input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts,
   input  logic                             deq_valid,
   input  logic [ENTRY_WIDTH-1:0]           deq_data,
   output logic                             deq_ready,
   output logic [N_ENTRIES-1:0]             deq_sel_onehot,
   output logic [N_ENTRIES-1:0]             wr_en,
   output logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data,
   input  logic                             bcast_valid,
   input  logic [TAG_WIDTH-1:0]             bcast_tag,
   output logic                             issue_valid,
   output logic [ENTRY_WIDTH-1:0]           issue_data,
   input  logic                             issue_ready
);
   localparam int CW = $clog2(ISSUE_II + 1);
   localparam int R1 = TAG_WIDTH + 1;

   logic [N_ENTRIES-1:0] cand, m1, m2;
   logic [CW-1:0]        ii_ctr;
   logic                 can_accept, deq_fire;

   for (genvar g = 0; g < N_ENTRIES; g++) begin : g_ent
      logic [ENTRY_WIDTH-1:0] e;
      assign e        = entry_douts[g*ENTRY_WIDTH +: ENTRY_WIDTH];
      assign m1[g]    = entry_valid[g] & bcast_valid & ~e[R1] & (e[2*TAG_WIDTH+1:TAG_WIDTH+2] == bcast_tag);
      assign m2[g]    = entry_valid[g] & bcast_valid & ~e[0] & (e[TAG_WIDTH:1] == bcast_tag);
      // selection looks only at stored ready bits; a wakeup this cycle is visible next cycle
      assign cand[g]  = entry_valid[g] & e[R1] & e[0];
      assign wr_en[g] = (m1[g] | m2[g]) & ~(deq_fire & deq_sel_onehot[g]) & ~flush;
      assign wr_data[g*ENTRY_WIDTH +: ENTRY_WIDTH] =
         wr_en[g] ? (e | (ENTRY_WIDTH'(m1[g]) << R1) | ENTRY_WIDTH'(m2[g])) : '0;
   end

   assign deq_sel_onehot = cand & -cand;
   assign can_accept     = (ii_ctr == '0) & (~issue_valid | issue_ready);
   assign deq_ready      = |cand & can_accept & ~flush;
   assign deq_fire       = deq_ready & deq_valid;

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         issue_valid <= 1'b0;
         issue_data  <= '0;
         ii_ctr      <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
         ii_ctr      <= '0;
      end else if (deq_fire) begin
         issue_valid <= 1'b1;
         issue_data  <= deq_data;
         ii_ctr      <= CW'(ISSUE_II - 1);
      end else begin
         if (issue_valid & issue_ready) issue_valid <= 1'b0;
         if (ii_ctr != '0) ii_ctr <= ii_ctr - CW'(1);
      end
   end
endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed steps against a small shift-queue model, with an issue scoreboard.
module tb_issue_select;
   localparam int N = 4, TW = 3, PW = 4, EW = PW + 2*TW + 2;

   logic clk = 1'b0, rst_aL = 1'b0, flush = 1'b0;
   logic bcast_valid = 1'b0, issue_ready = 1'b0;
   logic [TW-1:0] bcast_tag = '0;
   logic [N-1:0] entry_valid;
   logic [N*EW-1:0] entry_douts;
   logic deq_valid;
   logic [EW-1:0] deq_data, deq_data3;
   logic deq_ready, deq_ready3, issue_valid, issue_valid3;
   logic [N-1:0] sel, sel3, wr_en, wr_en3;
   logic [N*EW-1:0] wr_data, wr_data3;
   logic [EW-1:0] issue_data, issue_data3;

   logic [EW-1:0] q[N];
   int cnt = 0;
   bit use3 = 0;
   logic [EW-1:0] sb[$];
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      deq_valid = cnt != 0;
      deq_data  = '0;
      deq_data3 = '0;
      for (int i = 0; i < N; i++) begin
         entry_valid[i] = i < cnt;
         entry_douts[i*EW +: EW] = q[i];
         if (sel[i]) deq_data = q[i];
         if (sel3[i]) deq_data3 = q[i];
      end
   end

   issue_select #(.ISSUE_II(1)) dut (
      .clk(clk), .rst_aL(rst_aL), .flush(flush), .entry_valid(entry_valid), .entry_douts(entry_douts),
      .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready), .deq_sel_onehot(sel),
      .wr_en(wr_en), .wr_data(wr_data), .bcast_valid(bcast_valid), .bcast_tag(bcast_tag),
      .issue_valid(issue_valid), .issue_data(issue_data), .issue_ready(issue_ready));

   issue_select #(.ISSUE_II(3)) dut3 (
      .clk(clk), .rst_aL(rst_aL), .flush(flush), .entry_valid(entry_valid), .entry_douts(entry_douts),
      .deq_valid(deq_valid), .deq_data(deq_data3), .deq_ready(deq_ready3), .deq_sel_onehot(sel3),
      .wr_en(wr_en3), .wr_data(wr_data3), .bcast_valid(bcast_valid), .bcast_tag(bcast_tag),
      .issue_valid(issue_valid3), .issue_data(issue_data3), .issue_ready(issue_ready));

   function automatic logic [EW-1:0] mk(input int p, input int t1, input int r1, input int t2, input int r2);
      return {p[3:0], t1[2:0], r1[0], t2[2:0], r2[0]};
   endfunction

   function automatic logic [N*EW-1:0] lane(input int i, input logic [EW-1:0] v);
      return (N*EW)'(v) << (EW*i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [EW-1:0] v);
      q[cnt] = v;
      cnt++;
   endtask

   task automatic settle();
      #1;
   endtask

   // Scoreboard pop on FU handshake, then clock, then the queue model applies wakeups/dequeue.
   task automatic tick();
      logic f;
      logic [N-1:0] s, we;
      logic [N*EW-1:0] wd;
      logic [EW-1:0] nq[N];
      int j;
      f  = use3 ? (deq_ready3 & deq_valid) : (deq_ready & deq_valid);
      s  = use3 ? sel3 : sel;
      we = use3 ? wr_en3 : wr_en;
      wd = use3 ? wr_data3 : wr_data;
      if (!use3 && issue_valid && issue_ready) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) chk("sb_issue_data", 64'(issue_data), 64'(sb.pop_front()));
      end
      @(posedge clk);
      #1;
      j = 0;
      for (int i = 0; i < N; i++) nq[i] = '0;
      for (int i = 0; i < cnt; i++)
         if (!(f && s[i])) begin
            nq[j] = we[i] ? wd[i*EW +: EW] : q[i];
            j++;
         end
      cnt = j;
      for (int i = 0; i < N; i++) q[i] = nq[i];
   endtask

   initial begin
      for (int i = 0; i < N; i++) q[i] = '0;
      @(posedge clk);
      #1;
      chk("rst_issue_valid", 64'(issue_valid), 0);
      chk("rst_issue_data", 64'(issue_data), 0);
      chk("rst_deq_ready", 64'(deq_ready), 0);
      chk("rst_wr_en", 64'(wr_en), 0);
      rst_aL = 1'b1;
      issue_ready = 1'b1;
      // oldest entry waits on tag 5, entry 1 ready
      push(mk(1, 5, 0, 0, 1));
      push(mk(4'hA, 0, 1, 0, 1));
      settle();
      chk("a_sel", 64'(sel), 64'b0010);
      chk("a_deq_ready", 64'(deq_ready), 1);
      chk("a_wr_en", 64'(wr_en), 0);
      sb.push_back(mk(4'hA, 0, 1, 0, 1));
      tick();
      chk("a_issue_valid", 64'(issue_valid), 1);
      bcast_valid = 1'b1;
      bcast_tag = 3'd5;
      settle();
      chk("b_wr_en", 64'(wr_en), 64'b0001);
      chk("b_wr_data", 64'(wr_data), 64'(lane(0, mk(1, 5, 1, 0, 1))));
      chk("b_no_deq", 64'(deq_ready), 0);
      tick();
      bcast_valid = 1'b0;
      chk("b_issue_drained", 64'(issue_valid), 0);
      settle();
      chk("c_sel", 64'(sel), 64'b0001);
      chk("c_deq_ready", 64'(deq_ready), 1);
      sb.push_back(mk(1, 5, 1, 0, 1));
      tick();
      // src2 wakeup is written, but selection waits for the stored bit
      push(mk(3, 2, 1, 3, 0));
      bcast_valid = 1'b1;
      bcast_tag = 3'd3;
      settle();
      chk("d_wr_en", 64'(wr_en), 64'b0001);
      chk("d_wr_data", 64'(wr_data), 64'(lane(0, mk(3, 2, 1, 3, 1))));
      chk("d_no_deq", 64'(deq_ready), 0);
      tick();
      bcast_valid = 1'b0;
      settle();
      chk("d_sel", 64'(sel), 64'b0001);
      sb.push_back(mk(3, 2, 1, 3, 1));
      tick();
      // FU stall
      issue_ready = 1'b0;
      push(mk(5, 0, 1, 0, 1));
      settle();
      chk("e_stall_deq", 64'(deq_ready), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("e_hold_valid", 64'(issue_valid), 1);
         chk("e_hold_data", 64'(issue_data), 64'(mk(3, 2, 1, 3, 1)));
      end
      issue_ready = 1'b1;
      settle();
      chk("e_b2b_deq", 64'(deq_ready), 1);
      sb.push_back(mk(5, 0, 1, 0, 1));
      tick();
      chk("e_b2b_valid", 64'(issue_valid), 1);
      // dequeue entry 1 while entry 2 wakes
      push(mk(6, 7, 0, 0, 1));
      push(mk(7, 0, 1, 0, 1));
      push(mk(8, 6, 0, 0, 1));
      bcast_valid = 1'b1;
      bcast_tag = 3'd6;
      settle();
      chk("f_wr_en", 64'(wr_en), 64'b0100);
      chk("f_wr_data", 64'(wr_data), 64'(lane(2, mk(8, 6, 1, 0, 1))));
      chk("f_sel", 64'(sel), 64'b0010);
      chk("f_deq_ready", 64'(deq_ready), 1);
      sb.push_back(mk(7, 0, 1, 0, 1));
      tick();
      // both sources on one tag
      push(mk(9, 4, 0, 4, 0));
      bcast_tag = 3'd4;
      settle();
      chk("g_wr_en", 64'(wr_en), 64'b0100);
      chk("g_wr_data", 64'(wr_data), 64'(lane(2, mk(9, 4, 1, 4, 1))));
      chk("g_sel", 64'(sel), 64'b0010);
      sb.push_back(mk(8, 6, 1, 0, 1));
      tick();
      // flush discards the held op and blocks wakeup/dequeue
      flush = 1'b1;
      issue_ready = 1'b0;
      bcast_tag = 3'd7;
      settle();
      chk("h_flush_deq", 64'(deq_ready), 0);
      chk("h_flush_wr_en", 64'(wr_en), 0);
      tick();
      chk("h_flush_valid", 64'(issue_valid), 0);
      void'(sb.pop_front());
      flush = 1'b0;
      bcast_valid = 1'b0;
      issue_ready = 1'b1;
      settle();
      chk("h_sel", 64'(sel), 64'b0010);
      sb.push_back(mk(9, 4, 1, 4, 1));
      tick();
      bcast_valid = 1'b1;
      settle();
      chk("h_wr_en", 64'(wr_en), 64'b0001);
      chk("h_no_deq", 64'(deq_ready), 0);
      tick();
      bcast_valid = 1'b0;
      settle();
      chk("h_sel0", 64'(sel), 64'b0001);
      sb.push_back(mk(6, 7, 1, 0, 1));
      tick();
      chk("sb_drained", 64'(sb.size()), 1);
      // asynchronous reset mid-cycle drops the held op at once
      issue_ready = 1'b0;
      #2;
      rst_aL = 1'b0;
      #1;
      chk("arst_valid", 64'(issue_valid), 0);
      chk("arst_data", 64'(issue_data), 0);
      sb.delete();
      cnt = 0;
      // initiation interval of 3 on the second instance
      use3 = 1;
      @(posedge clk);
      #1;
      rst_aL = 1'b1;
      issue_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(mk(i, 0, 1, 0, 1));
      for (int k = 0; k < 10; k++) begin
         settle();
         chk("ii_deq_ready", 64'(deq_ready3), 64'(k % 3 == 0));
         chk("ii_ctr", 64'(dut3.ii_ctr), 64'((k % 3 == 0) ? 0 : 3 - k % 3));
         tick();
         if (k % 3 == 0) chk("ii_issue_data", 64'(issue_data3), 64'(mk(k / 3 + 1, 0, 1, 0, 1)));
      end
      push(mk(5, 2, 0, 0, 1));
      push(mk(6, 0, 1, 0, 1));
      bcast_valid = 1'b1;
      bcast_tag = 3'd2;
      flush = 1'b1;
      settle();
      chk("fl_ctr_before", 64'(dut3.ii_ctr), 2);
      chk("fl_deq_ready", 64'(deq_ready3), 0);
      chk("fl_wr_en", 64'(wr_en3), 0);
      tick();
      chk("fl_valid", 64'(issue_valid3), 0);
      chk("fl_ctr", 64'(dut3.ii_ctr), 0);
      flush = 1'b0;
      bcast_valid = 1'b0;
      settle();
      chk("fl_resume_deq", 64'(deq_ready3), 1);
      chk("fl_resume_sel", 64'(sel3), 64'b0010);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
